frogger_input_conditioner: RTL and testbench

FROGGER_INPUT_CONDITIONER -- requirements
Module: frogger_input_conditioner

---
 rtl/frogger_input_conditioner.sv | 129 ++++++++++++
 tb/tb_frogger_input_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/frogger_input_conditioner.sv
// Pushbutton conditioner: synchronize, debounce and arbitrate four active-low buttons into move strobes.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses; the default build emits one pulse per press.
module frogger_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 25000000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic [3:0] btn_level
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    // Refuse to elaborate with counts the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        longint'(DEBOUNCE_CYCLES) > CNT_MAX || longint'(REPEAT_DELAY) > CNT_MAX ||
        longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_cfg_check
        $error("frogger_input_conditioner: counts must be >= 1 and fit in CNT_W bits");
    end

    // Bit order everywhere is {up, down, left, right}.
    logic [3:0]       pins;
    logic [3:0]       sync1, sync2;
    logic [3:0]       pressed_sync;
    logic [3:0]       stable, stable_d;
    logic [3:0]       rise;
    logic [3:0]       press_evt;
    logic [3:0]       pulse_next;
    logic [3:0]       pulse_q;
    logic [CNT_W-1:0] db_cnt [4];

    assign pins         = {up, down, left, right};
    assign pressed_sync = ~sync2;
    assign rise         = stable & ~stable_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '1;
            sync2    <= '1;
            stable   <= '0;
            stable_d <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: every register here uses <= so all flops sample pre-edge values, like real hardware.
            sync1    <= pins;
            sync2    <= sync1;
            stable_d <= stable;
            pulse_q  <= pulse_next;
            for (int i = 0; i < 4; i++) begin
                if (pressed_sync[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= pressed_sync[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != CNT_SAT) begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // hold_cnt is 0 in the press-pulse cycle and restarts at each repeat pulse;
    // rep_phase selects the initial delay or the repeat period as the target.
    logic [CNT_W-1:0] hold_cnt [4];
    logic [3:0]       rep_phase;
    logic [3:0]       rep_evt;

    always_comb begin
        // NOTE: default first so every path assigns rep_evt and no latch is inferred.
        rep_evt = '0;
        for (int i = 0; i < 4; i++) begin
            if (stable[i] && stable_d[i] &&
                hold_cnt[i] == (rep_phase[i] ? PERIOD_LAST : DELAY_LAST))
                rep_evt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_phase <= '0;
            for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!stable[i] || rise[i]) begin
                    hold_cnt[i]  <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_evt[i]) begin
                    hold_cnt[i]  <= '0;
                    rep_phase[i] <= 1'b1;
                end else if (hold_cnt[i] != CNT_SAT) begin
                    hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_evt = rise | rep_evt;
`else
    assign press_evt = rise;
`endif

    // Opposing moves: up beats down, right beats left; the loser is dropped.
    always_comb begin
        pulse_next = press_evt;
        if (press_evt[3]) pulse_next[2] = 1'b0;
        if (press_evt[0]) pulse_next[1] = 1'b0;
    end

    assign {up_pulse, down_pulse, left_pulse, right_pulse} = pulse_q;
    assign btn_level = stable;

endmodule

// File: tb/tb_frogger_input_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse (edge, vector) pairs, a negedge monitor pops and compares.
// Edge N means the Nth rising edge after the one where a test drives its pins (pins change 1 ns after edge 0).
module tb_frogger_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right;
    logic       up_pulse, down_pulse, left_pulse, right_pulse;
    logic [3:0] btn_level;

    frogger_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse),
        .btn_level  (btn_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;
    } exp_t;

    exp_t       exp_q[$];
    int         ecount = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         base;
    logic [3:0] pulses;

    assign pulses = {up_pulse, down_pulse, left_pulse, right_pulse};

    always @(posedge clk) ecount <= ecount + 1;

    // Monitor: any asserted strobe must match the next expected entry in edge and value.
    always @(negedge clk) begin
        if (pulses != 4'b0000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: edge %0d got %b, expected none", ecount, pulses);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != ecount || e.pulses != pulses) begin
                    miscompares++;
                    $display("FAIL pulse: edge %0d got %b, expected edge %0d value %b",
                             ecount, pulses, e.cyc, e.pulses);
                end
            end
        end
    end

    task automatic expect_pulse(input int cyc, input logic [3:0] p);
        exp_t e;
        e.cyc    = cyc;
        e.pulses = p;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_test();
        step(1);
        base = ecount;
    endtask

    initial begin
        {up, down, left, right} = 4'b1111;
        reset = 1'b1;
        step(3);
        check("reset_level", btn_level, 4'b0000);
        check("reset_pulses", pulses, 4'b0000);
        reset = 1'b0;
        step(5);

        // Clean press of up: level from edge 6, single pulse on edge 7.
        start_test();
        up = 1'b0;
        expect_pulse(base + 7, 4'b1000);
        step(5);
        check("up_level_e5", btn_level, 4'b0000);
        step(1);
        check("up_level_e6", btn_level, 4'b1000);
        step(2);
        up = 1'b1;
        step(12);
        check("up_released", btn_level, 4'b0000);

        // Bouncing left: low 2, high 1, low hold; final fall after edge 3 -> pulse at edge 10.
        start_test();
        left = 1'b0;
        step(2);
        left = 1'b1;
        step(1);
        left = 1'b0;
        expect_pulse(base + 10, 4'b0010);
        step(5);
        check("left_level_e8", btn_level, 4'b0000);
        step(1);
        check("left_level_e9", btn_level, 4'b0010);
        step(2);
        left = 1'b1;
        step(12);
        check("left_released", btn_level, 4'b0000);

        // Up and down together: only up pulses, both levels shown.
        start_test();
        up   = 1'b0;
        down = 1'b0;
        expect_pulse(base + 7, 4'b1000);
        step(6);
        check("updown_level", btn_level, 4'b1100);
        step(2);
        up   = 1'b1;
        down = 1'b1;
        step(12);
        check("updown_released", btn_level, 4'b0000);

        // Right held across a one-cycle reset at edge 5: single pulse at edge 13.
        start_test();
        right = 1'b0;
        expect_pulse(base + 13, 4'b0001);
        step(5);
        reset = 1'b1;
        #1;
        check("midreset_level", btn_level, 4'b0000);
        check("midreset_pulses", pulses, 4'b0000);
        step(1);
        reset = 1'b0;
        step(5);
        check("right_level_e11", btn_level, 4'b0000);
        step(1);
        check("right_level_e12", btn_level, 4'b0001);
        step(2);
        right = 1'b1;
        step(12);
        check("right_released", btn_level, 4'b0000);

        // Down held 30 cycles. With repeat: pulses at 7, 17, 20, ... until the debounced
        // release lands at edge 36 (pin released after edge 30), so the last one is edge 35.
        start_test();
        down = 1'b0;
        expect_pulse(base + 7, 4'b0100);
`ifdef AUTO_REPEAT_EN
        for (int c = 7 + RD; c <= 35; c += RP) expect_pulse(base + c, 4'b0100);
`endif
        step(30);
        check("down_held_level", btn_level, 4'b0100);
        down = 1'b1;
        step(15);
        check("down_released", btn_level, 4'b0000);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, first at edge %0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
